// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard unit
package pipe_pkg;

    localparam int PIPE_REG_AW = 5;
    localparam int PIPE_DEPTH  = 3;

    // Entries store rd at a fixed width so the struct is parameter independent; REG_AW must not exceed this.
    localparam int REG_AW_MAX = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wen;
        logic                  load;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - matches one ID source register against the non-WB scoreboard entries
module pipe_hazard_cmp
    import pipe_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW,
    parameter int DEPTH  = PIPE_DEPTH,
    parameter int IDXW   = $clog2(DEPTH)
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  pipe_entry_t       ents [DEPTH-1],
    output logic [DEPTH-2:0]  hit,
    output logic [IDXW-1:0]   youngest
);

    logic [REG_AW_MAX-1:0] src_ext;

    assign src_ext = REG_AW_MAX'(src);

    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            hit[k] = src_used && (src != '0) && ents[k].valid && ents[k].wen
                     && (ents[k].rd == src_ext);
        end
    end

    // Scan oldest to youngest so the lowest matching index is what remains.
    always_comb begin
        youngest = '0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (hit[k]) begin
                youngest = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - ID-stage stall/forward decision; PIPE_HAZARD_FWD_EN enables forwarding
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW,
    parameter int DEPTH  = PIPE_DEPTH,
    parameter int SELW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SELW-1:0]   fwd_a_sel,
    output logic [SELW-1:0]   fwd_b_sel,
    output logic [31:0]       stall_cnt
);

    localparam int IDXW = $clog2(DEPTH);

    pipe_entry_t      ents_q   [DEPTH];
    pipe_entry_t      cmp_ents [DEPTH-1];
    pipe_entry_t      id_entry;
    logic [DEPTH-2:0] hit_a;
    logic [DEPTH-2:0] hit_b;
    logic [IDXW-1:0]  young_a;
    logic [IDXW-1:0]  young_b;
    logic             stall_raw;
    logic [SELW-1:0]  fwd_a_raw;
    logic [SELW-1:0]  fwd_b_raw;
    logic             id_live;
    logic [31:0]      stall_cnt_q;

    // WB is excluded: the register file writes before it is read.
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++) begin
            cmp_ents[k] = ents_q[k];
        end
    end

    pipe_hazard_cmp #(.REG_AW(REG_AW), .DEPTH(DEPTH), .IDXW(IDXW)) u_cmp_rs (
        .src      (id_rs),
        .src_used (id_rs_used),
        .ents     (cmp_ents),
        .hit      (hit_a),
        .youngest (young_a)
    );

    pipe_hazard_cmp #(.REG_AW(REG_AW), .DEPTH(DEPTH), .IDXW(IDXW)) u_cmp_rt (
        .src      (id_rt),
        .src_used (id_rt_used),
        .ents     (cmp_ents),
        .hit      (hit_b),
        .youngest (young_b)
    );

`ifdef PIPE_HAZARD_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign stall_raw = ((|hit_a) && (young_a == '0) && ents_q[0].load)
                    || ((|hit_b) && (young_b == '0) && ents_q[0].load);
    assign fwd_a_raw = (|hit_a) ? SELW'(young_a) + SELW'(1) : SELW'(FWD_RF);
    assign fwd_b_raw = (|hit_b) ? SELW'(young_b) + SELW'(1) : SELW'(FWD_RF);
`else
    logic unused_young;

    assign unused_young = ^{young_a, young_b};
    assign stall_raw    = (|hit_a) || (|hit_b);
    assign fwd_a_raw    = SELW'(FWD_RF);
    assign fwd_b_raw    = SELW'(FWD_RF);
`endif

    assign id_live   = id_valid && !flush;
    assign stall     = id_live && stall_raw;
    assign fwd_a_sel = id_live ? fwd_a_raw : SELW'(FWD_RF);
    assign fwd_b_sel = id_live ? fwd_b_raw : SELW'(FWD_RF);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.rd    = REG_AW_MAX'(id_rd);
        id_entry.wen   = id_wen;
        id_entry.load  = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ents_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            ents_q[0] <= (id_live && !stall) ? id_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                ents_q[k] <= ents_q[k-1];
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_is_load;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    pipe_hazard_unit #(.REG_AW(5), .DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_wen     (id_wen),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic [4:0] rd,
                          input logic wen, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            flush = 1'b0;
            id_set(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        id_set(1, 3, 3, 1, 1, 4, 1, 0);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_fwd_a", 32'(fwd_a_sel), 0);
        check("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);

        // ADD r3 ; SUB r4,r3,r1 ; AND r5,r3,r1 ; OR r6,r3,r1
        cyc(); id_set(1, 1, 2, 1, 1, 3, 1, 0); #1;
        check("add_stall", 32'(stall), 0);
        cyc(); id_set(1, 3, 1, 1, 1, 4, 1, 0); #1;
        check("sub_stall", 32'(stall), FWD ? 0 : 1);
        check("sub_fwd_a", 32'(fwd_a_sel), FWD ? 1 : 0);
        check("sub_fwd_b", 32'(fwd_b_sel), 0);
        exp_cnt += FWD ? 0 : 1;
        cyc(); id_set(1, 3, 1, 1, 1, 5, 1, 0); #1;
        check("and_stall", 32'(stall), FWD ? 0 : 1);
        check("and_fwd_a", 32'(fwd_a_sel), FWD ? 2 : 0);
        exp_cnt += FWD ? 0 : 1;
        cyc(); id_set(1, 3, 1, 1, 1, 6, 1, 0); #1;
        check("wb_stall", 32'(stall), 0);
        check("wb_fwd_a", 32'(fwd_a_sel), 0);
        check("chain_cnt", stall_cnt, 32'(exp_cnt));
        idle(4);

        // r0 is never a hazard; unused sources ignored; rt path forwarding
        cyc(); id_set(1, 1, 2, 1, 1, 0, 1, 1); #1;
        check("r0_wr_stall", 32'(stall), 0);
        cyc(); id_set(1, 0, 0, 1, 1, 8, 1, 0); #1;
        check("r0_rd_stall", 32'(stall), 0);
        check("r0_fwd_a", 32'(fwd_a_sel), 0);
        check("r0_fwd_b", 32'(fwd_b_sel), 0);
        cyc(); id_set(1, 1, 1, 1, 1, 7, 1, 1); #1;
        check("lw7_stall", 32'(stall), 0);
        cyc(); id_set(1, 7, 7, 0, 0, 9, 1, 0); #1;
        check("unused_stall", 32'(stall), 0);
        check("unused_fwd_a", 32'(fwd_a_sel), 0);
        cyc(); id_set(1, 1, 7, 0, 1, 9, 1, 0); #1;
        check("rt_stall", 32'(stall), FWD ? 0 : 1);
        check("rt_fwd_b", 32'(fwd_b_sel), FWD ? 2 : 0);
        exp_cnt += FWD ? 0 : 1;
        idle(4);

        // youngest match wins: LW r3 older, ADD r3 younger
        cyc(); id_set(1, 1, 2, 1, 1, 3, 1, 1); #1;
        check("yw_lw_stall", 32'(stall), 0);
        cyc(); id_set(1, 1, 2, 1, 1, 3, 1, 0); #1;
        check("yw_add_stall", 32'(stall), 0);
        cyc(); id_set(1, 3, 3, 1, 1, 10, 1, 0); #1;
        check("yw_stall", 32'(stall), FWD ? 0 : 1);
        check("yw_fwd_a", 32'(fwd_a_sel), FWD ? 1 : 0);
        check("yw_fwd_b", 32'(fwd_b_sel), FWD ? 1 : 0);
        exp_cnt += FWD ? 0 : 1;
        idle(4);

        // load-use: LW r2 ; ADD r6,r2,r2
        cyc(); id_set(1, 1, 0, 1, 0, 2, 1, 1); #1;
        check("lu_lw_stall", 32'(stall), 0);
        cyc(); id_set(1, 2, 2, 1, 1, 6, 1, 0); id_valid = 1'b0; #1;
        check("inv_stall", 32'(stall), 0);
        check("inv_fwd_a", 32'(fwd_a_sel), 0);
        id_valid = 1'b1; #1;
        check("lu_stall", 32'(stall), 1);
        exp_cnt += 1;
        cyc(); #1;
        check("lu_cnt1", stall_cnt, 32'(exp_cnt));
        check("lu_stall2", 32'(stall), FWD ? 0 : 1);
        check("lu_fwd_a", 32'(fwd_a_sel), FWD ? 2 : 0);
        check("lu_fwd_b", 32'(fwd_b_sel), FWD ? 2 : 0);
        exp_cnt += FWD ? 0 : 1;
        cyc(); #1;
        check("lu_stall3", 32'(stall), 0);
        check("lu_fwd_a3", 32'(fwd_a_sel), 0);
        check("lu_cnt2", stall_cnt, 32'(exp_cnt));
        idle(4);

        // flush beats stall; flushed instruction never enters EX
        cyc(); id_set(1, 1, 0, 1, 0, 2, 1, 1); #1;
        cyc(); id_set(1, 2, 2, 1, 1, 9, 1, 1); flush = 1'b1; #1;
        check("fl_stall", 32'(stall), 0);
        check("fl_fwd_a", 32'(fwd_a_sel), 0);
        cyc(); flush = 1'b0; id_set(1, 9, 2, 1, 0, 10, 1, 0); #1;
        check("fl_bubble_stall", 32'(stall), 0);
        check("fl_bubble_fwd", 32'(fwd_a_sel), 0);
        check("fl_cnt", stall_cnt, 32'(exp_cnt));
        idle(4);

        // reset during load-use stall
        cyc(); id_set(1, 1, 0, 1, 0, 2, 1, 1); #1;
        cyc(); id_set(1, 2, 0, 1, 0, 6, 1, 0); #1;
        check("rs_pre_stall", 32'(stall), 1);
        rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        check("rs_stall", 32'(stall), 0);
        check("rs_cnt", stall_cnt, 0);
        idle(4);

        // counter saturation
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        cyc(); id_set(1, 1, 0, 1, 0, 2, 1, 1); #1;
        cyc(); id_set(1, 2, 0, 1, 0, 6, 1, 0); #1;
        check("sat_stall1", 32'(stall), 1);
        cyc(); id_set(1, 1, 0, 1, 0, 2, 1, 1); #1;
        check("sat_cnt1", stall_cnt, 32'hFFFF_FFFF);
        check("sat_lw_stall", 32'(stall), 0);
        cyc(); id_set(1, 2, 0, 1, 0, 6, 1, 0); #1;
        check("sat_stall2", 32'(stall), 1);
        idle(1); #1;
        check("sat_cnt2", stall_cnt, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter: REG_AW, default 5, register-index width (2**REG_AW architectural registers; register 0 hard-wired zero).
REQ-002 Parameter: DEPTH, default 3, number of tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..8.
REQ-003 Parameter: SELW, default $clog2(DEPTH+1), forward-select width.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: id_valid  in  1  ID stage holds a real instruction.
REQ-007 Port: id_rs, id_rt  in  REG_AW each  source register indices.
REQ-008 Port: id_rs_used, id_rt_used  in  1 each  corresponding source is actually read.
REQ-009 Port: id_rd  in  REG_AW  destination index; id_wen in 1 instruction writes id_rd; id_is_load in 1 result comes from memory.
REQ-010 Port: flush  in  1  taken branch/jump resolved in EX; discard the ID instruction.
REQ-011 Port: stall  out  1  hold PC and IF/ID register, insert bubble into EX.
REQ-012 Port: fwd_a_sel, fwd_b_sel  out  SELW each  0 = register file, k = result of entry k-1.
REQ-013 Port: stall_cnt  out  32  count of cycles with stall asserted.

Function
REQ-014 Scoreboard: DEPTH entries {valid, rd, wen, load}; entry k advances to k+1 every cycle; entry DEPTH-1 retires unconditionally.
REQ-015 Entry 0 next value: ID instruction when id_valid & ~stall & ~flush; bubble (valid=0) otherwise.
REQ-016 Match(src, k): src_used & src!=0 & entry[k].valid & entry[k].wen & entry[k].rd==src.
REQ-017 Entry DEPTH-1 (WB) never causes a hazard or forward; the register file provides write-before-read.
REQ-018 stall, fwd_*_sel combinational from current entries and ID inputs; zero-cycle latency.
REQ-019 stall and fwd_*_sel forced to 0 when id_valid=0 or flush=1.
REQ-020 Youngest-wins: when several entries match the same source, the lowest index k selects/decides.
REQ-021 flush and stall same cycle: flush wins; stall=0, bubble enters entry 0, stall_cnt unchanged.
REQ-022 stall_cnt increments by 1 on each cycle stall=1; saturates at 32'hFFFF_FFFF (no wrap).
REQ-023 A stalled ID instruction re-evaluates every cycle; stall drops on the first cycle its hazard clears.

Reset
REQ-024 rst=1 at a clock edge: all entries valid=0, stall_cnt=0; thus stall=0, fwd_*_sel=0 the cycle after.
REQ-025 rst mid-stall or mid-flush discards all in-flight entries; no residual stall after release.

Configuration
REQ-026 Macro PIPE_HAZARD_FWD_EN defined: forwarding on; fwd_*_sel = k+1 for youngest matching non-WB entry k; stall=1 only when the youngest match for a used source is entry 0 with load=1 (load-use, one bubble).
REQ-027 Macro PIPE_HAZARD_FWD_EN undefined: fwd_*_sel tied to 0; stall=1 whenever any used source matches any entry 0..DEPTH-2.

Structure
REQ-028 Shared package pipe_pkg holds: entry struct typedef (valid, rd, wen, load), fwd-select encoding constants (FWD_RF=0), default REG_AW/DEPTH constants.
REQ-029 One sub-module pipe_hazard_cmp: per-source comparison against all entries, returning hit vector and youngest index; instantiated twice (rs, rt).

Verification
REQ-030 FWD_EN, DEPTH=3: ADD r3 then SUB r4,r3,r1 back-to-back -> stall=0, fwd_a_sel=1 on SUB; next: AND r5,r3 -> fwd_a_sel=2.
REQ-031 FWD_EN: LW r2 then ADD r6,r2,r2 -> stall=1 one cycle, stall_cnt=1, then fwd_a_sel=fwd_b_sel=2.
REQ-032 No FWD_EN, DEPTH=3: ADD r3 then use r3 -> stall=1 for 2 cycles, then stall=0, fwd_a_sel=0.
REQ-033 Write to r0 then read r0 -> stall=0, fwd_*_sel=0 in both modes.
REQ-034 LW r2 followed by dependent use with flush=1 same cycle -> stall=0, stall_cnt unchanged, entry 0 bubble.
REQ-035 rst asserted during a load-use stall -> next cycle stall=0, stall_cnt=0; preload stall_cnt=32'hFFFF_FFFF, stall again -> stays 32'hFFFF_FFFF.
